// File: rtl/column_frame_renderer.sv
// column_frame_renderer
// Renders one raycast frame column by column. Each column descriptor (wall
// height and colour) arrives over a valid/ready handshake. The renderer then
// emits one registered frame-buffer write per cycle.
//   MODE = 0 (FILL):  ceiling, wall and floor are written for every row.
//   MODE = 1 (CLEAR): a full-screen clear pass runs first, then only the
//                     wall span of each column is drawn.
module column_frame_renderer #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int COLOR_W     = 3,
    parameter int MODE        = 0,
    parameter int CLEAR_COLOR = 0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               frame_start,
    input  logic [COLOR_W-1:0] ceil_color,
    input  logic [COLOR_W-1:0] floor_color,
    output logic [XW-1:0]      col_index,
    output logic               col_ready,
    input  logic               col_valid,
    input  logic [YW-1:0]      col_height,
    input  logic [COLOR_W-1:0] col_color,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_we,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Row arithmetic is one bit wider than pix_y so SCREEN_H itself and
    // top + h never wrap.
    localparam logic [YW:0]         H_LIM      = (YW+1)'(SCREEN_H);
    localparam logic [YW:0]         ONE_EXT    = (YW+1)'(1);
    localparam logic [XW-1:0]       X_LAST     = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0]       Y_LAST     = YW'(SCREEN_H - 1);
    localparam logic [COLOR_W-1:0]  CLEAR_C    = COLOR_W'(CLEAR_COLOR);
    localparam bit                  CLEAR_MODE = (MODE == 1);

    logic [2:0]         state;
    logic [2:0]         next_state;

    // Frame-wide colours, latched when a frame is accepted.
    logic [COLOR_W-1:0] ceil_q;
    logic [COLOR_W-1:0] floor_q;

    // Current column descriptor.
    logic [COLOR_W-1:0] wall_color;
    logic [YW:0]        top;
    logic [YW:0]        bot;

    // Raster counters: cx is used only by the clear pass, row is shared by
    // the clear pass (as cy) and the column draw.
    logic [XW-1:0]      cx;
    logic [YW-1:0]      row;

    // Descriptor geometry computed from the live handshake inputs.
    logic [YW:0]        h_clamp;
    logic [YW:0]        top_calc;
    logic [YW:0]        bot_calc;

    logic               accept;
    logic               skip_col;
    logic               col_last;
    logic               row_last;
    logic               clear_last;
    logic               col_advance;
    logic [COLOR_W-1:0] draw_color;

    assign accept      = (state == S_REQ) && col_valid;
    assign skip_col    = CLEAR_MODE && (h_clamp == '0);
    assign col_last    = (col_index == X_LAST);
    assign clear_last  = (cx == X_LAST) && (row == Y_LAST);
    assign col_advance = ((state == S_DRAW) && row_last) || (accept && skip_col);

    // Status outputs decode directly from the state register, so reset
    // drives them low on the same edge as the state.
    assign busy       = (state != S_IDLE);
    assign col_ready  = (state == S_REQ);
    assign frame_done = (state == S_DONE);

    // Clamp the wall height and centre it; an odd spare row lands below.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        h_clamp  = {1'b0, col_height};
        if ({1'b0, col_height} > H_LIM) begin
            h_clamp = H_LIM;
        end
        top_calc = (H_LIM - h_clamp) >> 1;
        bot_calc = top_calc + h_clamp;
    end

    // Pick the colour of the current row and detect the column's last row.
    always_comb begin
        draw_color = wall_color;
        row_last   = (row == Y_LAST);
        if (CLEAR_MODE) begin
            row_last = ({1'b0, row} == (bot - ONE_EXT));
        end else if ({1'b0, row} < top) begin
            draw_color = ceil_q;
        end else if ({1'b0, row} >= bot) begin
            draw_color = floor_q;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    next_state = CLEAR_MODE ? S_CLEAR : S_REQ;
                end
            end
            S_CLEAR: begin
                if (clear_last) begin
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (col_valid) begin
                    if (skip_col) begin
                        next_state = col_last ? S_DONE : S_REQ;
                    end else begin
                        next_state = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                if (row_last) begin
                    next_state = col_last ? S_DONE : S_REQ;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the frame colours when a new frame is accepted.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ceil_q  <= '0;
            floor_q <= '0;
        end else if ((state == S_IDLE) && frame_start) begin
            ceil_q  <= ceil_color;
            floor_q <= floor_color;
        end
    end

    // Column index: cleared at frame start, stepped after each column.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            col_index <= '0;
        end else if ((state == S_IDLE) && frame_start) begin
            col_index <= '0;
        end else if (col_advance && !col_last) begin
            col_index <= col_index + 1'b1;
        end
    end

    // Capture the column descriptor on the handshake.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wall_color <= '0;
            top        <= '0;
            bot        <= '0;
        end else if (accept) begin
            wall_color <= col_color;
            top        <= top_calc;
            bot        <= bot_calc;
        end
    end

    // Raster counters for the clear pass and the per-column row walk.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cx  <= '0;
            row <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        cx  <= '0;
                        row <= '0;
                    end
                end
                S_CLEAR: begin
                    if (cx == X_LAST) begin
                        cx  <= '0;
                        row <= (row == Y_LAST) ? '0 : row + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                S_REQ: begin
                    if (col_valid) begin
                        row <= CLEAR_MODE ? top_calc[YW-1:0] : '0;
                    end
                end
                S_DRAW: begin
                    if (!row_last) begin
                        row <= row + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered write port: a pixel generated this cycle appears next cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            pix_we    <= 1'b0;
        end else begin
            pix_we <= 1'b0;
            if (state == S_CLEAR) begin
                pix_x     <= cx;
                pix_y     <= row;
                pix_color <= CLEAR_C;
                pix_we    <= 1'b1;
            end else if (state == S_DRAW) begin
                pix_x     <= col_index;
                pix_y     <= row;
                pix_color <= draw_color;
                pix_we    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_column_frame_renderer.sv
// Testbench for column_frame_renderer: one FILL-mode and one CLEAR-mode
// instance at 160x120, checked against a row-by-row reference model.
module tb_column_frame_renderer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int CLR = 0;

    typedef struct packed {
        int x;
        int y;
        int c;
    } pix_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #10 clock = ~clock;

    // FILL instance signals
    logic       f_start = 1'b0;
    logic [2:0] f_ceil  = '0;
    logic [2:0] f_floor = '0;
    logic [7:0] f_col_index;
    logic       f_col_ready;
    logic       f_col_valid = 1'b1;
    logic [6:0] f_col_height;
    logic [2:0] f_col_color;
    logic [7:0] f_pix_x;
    logic [6:0] f_pix_y;
    logic [2:0] f_pix_color;
    logic       f_pix_we, f_busy, f_frame_done;
    logic [6:0] f_hgt [W];
    logic [2:0] f_clr [W];

    // CLEAR instance signals
    logic       c_start = 1'b0;
    logic [2:0] c_ceil  = '0;
    logic [2:0] c_floor = '0;
    logic [7:0] c_col_index;
    logic       c_col_ready;
    logic       c_col_valid = 1'b1;
    logic [6:0] c_col_height;
    logic [2:0] c_col_color;
    logic [7:0] c_pix_x;
    logic [6:0] c_pix_y;
    logic [2:0] c_pix_color;
    logic       c_pix_we, c_busy, c_frame_done;
    logic [6:0] c_hgt [W];
    logic [2:0] c_clr [W];

    // Slice computer stand-in: presents the descriptor of the requested column.
    assign f_col_height = f_hgt[f_col_index];
    assign f_col_color  = f_clr[f_col_index];
    assign c_col_height = c_hgt[c_col_index];
    assign c_col_color  = c_clr[c_col_index];

    column_frame_renderer #(.MODE(0)) u_fill (
        .clock(clock), .resetn(resetn), .frame_start(f_start),
        .ceil_color(f_ceil), .floor_color(f_floor),
        .col_index(f_col_index), .col_ready(f_col_ready), .col_valid(f_col_valid),
        .col_height(f_col_height), .col_color(f_col_color),
        .pix_x(f_pix_x), .pix_y(f_pix_y), .pix_color(f_pix_color), .pix_we(f_pix_we),
        .busy(f_busy), .frame_done(f_frame_done)
    );

    column_frame_renderer #(.MODE(1), .CLEAR_COLOR(CLR)) u_clear (
        .clock(clock), .resetn(resetn), .frame_start(c_start),
        .ceil_color(c_ceil), .floor_color(c_floor),
        .col_index(c_col_index), .col_ready(c_col_ready), .col_valid(c_col_valid),
        .col_height(c_col_height), .col_color(c_col_color),
        .pix_x(c_pix_x), .pix_y(c_pix_y), .pix_color(c_pix_color), .pix_we(c_pix_we),
        .busy(c_busy), .frame_done(c_frame_done)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   f_done_cnt = 0;
    int   c_done_cnt = 0;
    pix_t f_got[$];
    pix_t c_got[$];
    pix_t exp_q[$];

    // Write monitor: records every frame-buffer write and frame_done pulse.
    always @(negedge clock) begin
        pix_t p;
        if (f_pix_we) begin
            p.x = int'(f_pix_x); p.y = int'(f_pix_y); p.c = int'(f_pix_color);
            f_got.push_back(p);
        end
        if (c_pix_we) begin
            p.x = int'(c_pix_x); p.y = int'(c_pix_y); p.c = int'(c_pix_color);
            c_got.push_back(p);
        end
        if (f_frame_done) f_done_cnt++;
        if (c_frame_done) c_done_cnt++;
    end

    // Reference model: the write sequence a frame must produce.
    task automatic build_expect(input bit clear_mode, input int ceil_c, input int floor_c);
        pix_t p;
        int hv, wall, h, top, bot;
        exp_q.delete();
        if (clear_mode) begin
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    p.x = x; p.y = y; p.c = CLR;
                    exp_q.push_back(p);
                end
            end
        end
        for (int x = 0; x < W; x++) begin
            hv   = clear_mode ? int'(c_hgt[x]) : int'(f_hgt[x]);
            wall = clear_mode ? int'(c_clr[x]) : int'(f_clr[x]);
            h    = (hv > H) ? H : hv;
            top  = (H - h) / 2;
            bot  = top + h;
            for (int y = 0; y < H; y++) begin
                p.x = x; p.y = y;
                if (y < top)      p.c = ceil_c;
                else if (y < bot) p.c = wall;
                else              p.c = floor_c;
                if (!clear_mode || (y >= top && y < bot)) exp_q.push_back(p);
            end
        end
    endtask

    // Index of the first write that differs from the model, or -1.
    function automatic int first_diff(input bit clear_mode);
        int n;
        pix_t g;
        n = clear_mode ? c_got.size() : f_got.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= n) return i;
            g = clear_mode ? c_got[i] : f_got[i];
            if (g !== exp_q[i]) return i;
        end
        if (n != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    // Bounded wait on a DUT event: 0 fill frame_done, 1 clear frame_done,
    // 2 clear col_ready, 3 fill column 80 in draw.
    task automatic wait_for(input int which, input int budget, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            n++;
            if ((which == 0 && f_frame_done) || (which == 1 && c_frame_done) ||
                (which == 2 && c_col_ready) ||
                (which == 3 && f_col_index == 8'd80 && !f_col_ready)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_fill(input logic [2:0] ceil_c, input logic [2:0] floor_c);
        @(negedge clock);
        f_ceil = ceil_c; f_floor = floor_c; f_start = 1'b1;
        @(negedge clock);
        f_start = 1'b0;
        f_ceil  = ~ceil_c;
        f_floor = ~floor_c;
    endtask

    task automatic report_pixels(input string name, input bit clear_mode);
        int d;
        int n;
        pix_t g;
        d = first_diff(clear_mode);
        n = clear_mode ? c_got.size() : f_got.size();
        n_cmp++;
        if (d >= 0) begin
            n_err++;
            g = '0;
            if (d < n) g = clear_mode ? c_got[d] : f_got[d];
            if (d < exp_q.size())
                $display("FAIL %s: write %0d got (%0d,%0d,c%0d) of %0d writes, required (%0d,%0d,c%0d) of %0d",
                         name, d, g.x, g.y, g.c, n, exp_q[d].x, exp_q[d].y, exp_q[d].c, exp_q.size());
            else
                $display("FAIL %s: got %0d writes, required %0d", name, n, exp_q.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({f_col_index, f_col_ready, f_pix_x, f_pix_y, f_pix_color, f_pix_we, f_busy, f_frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_fill: outputs %h, required 0",
                     {f_col_index, f_col_ready, f_pix_x, f_pix_y, f_pix_color, f_pix_we, f_busy, f_frame_done});
        end
        n_cmp++;
        if ({c_col_index, c_col_ready, c_pix_x, c_pix_y, c_pix_color, c_pix_we, c_busy, c_frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_clear: outputs %h, required 0",
                     {c_col_index, c_col_ready, c_pix_x, c_pix_y, c_pix_color, c_pix_we, c_busy, c_frame_done});
        end
        resetn = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_fill_basic();
        int  n;
        bit  ok;
        int  d0;
        for (int x = 0; x < W; x++) begin
            f_hgt[x] = 7'd40;
            f_clr[x] = 3'd5;
        end
        build_expect(1'b0, 1, 2);
        f_got.delete();
        d0 = f_done_cnt;
        f_col_valid = 1'b1;
        start_fill(3'd1, 3'd2);
        n_cmp++;
        if (f_col_ready !== 1'b1 || f_col_index !== 8'd0 || f_busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_first_req: ready=%b index=%0d busy=%b, required 1/0/1",
                     f_col_ready, f_col_index, f_busy);
        end
        wait_for(0, 25000, n, ok);
        n_cmp++;
        if (!ok || n != W * (H + 1)) begin
            n_err++;
            $display("FAIL basic_latency: frame_done after %0d cycles (seen=%b), required %0d", n, ok, W * (H + 1));
        end
        n_cmp++;
        if (f_pix_we !== 1'b1 || f_pix_x !== 8'd159 || f_pix_y !== 7'd119 || f_pix_color !== 3'd2) begin
            n_err++;
            $display("FAIL basic_last_pixel: we=%b x=%0d y=%0d c=%0d, required 1/159/119/2",
                     f_pix_we, f_pix_x, f_pix_y, f_pix_color);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (f_got.size() != W * H) begin
            n_err++;
            $display("FAIL basic_write_count: got %0d, required %0d", f_got.size(), W * H);
        end
        report_pixels("basic_pixels", 1'b0);
        n_cmp++;
        if (f_done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL basic_done_count: got %0d, required 1", f_done_cnt - d0);
        end
    endtask

    task automatic test_random_fill();
        int         n;
        bit         ok;
        int         d0;
        logic [2:0] cc, fc;
        for (int x = 0; x < W; x++) begin
            f_hgt[x] = 7'($urandom_range(0, 127));
            f_clr[x] = 3'($urandom_range(0, 7));
        end
        f_hgt[0] = 7'd121;
        f_hgt[1] = 7'd0;
        f_hgt[2] = 7'd120;
        f_hgt[3] = 7'd119;
        f_hgt[4] = 7'd1;
        f_hgt[5] = 7'd127;
        cc = 3'($urandom_range(0, 7));
        fc = 3'($urandom_range(0, 7));
        build_expect(1'b0, int'(cc), int'(fc));
        f_got.delete();
        d0 = f_done_cnt;
        f_col_valid = 1'b1;
        start_fill(cc, fc);

        // Stall the descriptor for column 7.
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clock);
            if (f_col_index == 8'd7) ok = 1'b1;
        end
        f_col_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL stall_reach: column 7 not requested, index=%0d", f_col_index);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_cmp++;
            if (f_col_ready !== 1'b1 || f_col_index !== 8'd7 || f_pix_we !== 1'b0) begin
                n_err++;
                $display("FAIL stall_cycle%0d: ready=%b index=%0d we=%b, required 1/7/0",
                         i, f_col_ready, f_col_index, f_pix_we);
            end
        end
        f_col_valid = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (f_col_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_accept: ready=%b after valid rose, required 0", f_col_ready);
        end
        @(negedge clock);
        n_cmp++;
        if (f_pix_we !== 1'b1 || f_pix_x !== 8'd7 || f_pix_y !== 7'd0) begin
            n_err++;
            $display("FAIL stall_resume: we=%b x=%0d y=%0d, required 1/7/0", f_pix_we, f_pix_x, f_pix_y);
        end

        // A frame request during column 50 must be ignored.
        ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            @(negedge clock);
            if (f_col_index == 8'd50 && !f_col_ready) ok = 1'b1;
        end
        f_start = 1'b1;
        f_ceil  = ~cc;
        @(negedge clock);
        f_start = 1'b0;

        wait_for(0, 25000, n, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL random_done: frame_done not seen within %0d cycles", n);
        end
        repeat (5) @(negedge clock);
        n_cmp++;
        if (f_busy !== 1'b0 || f_col_ready !== 1'b0 || f_pix_we !== 1'b0) begin
            n_err++;
            $display("FAIL random_idle: busy=%b ready=%b we=%b, required 0/0/0", f_busy, f_col_ready, f_pix_we);
        end
        n_cmp++;
        if (f_done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL random_done_count: got %0d, required 1", f_done_cnt - d0);
        end
        report_pixels("random_pixels", 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int  n;
        bit  ok;
        int  d0;
        for (int x = 0; x < W; x++) begin
            f_hgt[x] = 7'($urandom_range(0, 127));
            f_clr[x] = 3'($urandom_range(0, 7));
        end
        f_col_valid = 1'b1;
        d0 = f_done_cnt;
        start_fill(3'd3, 3'd4);
        wait_for(3, 12000, n, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL midreset_reach: column 80 draw not reached, index=%0d", f_col_index);
        end
        resetn = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({f_col_index, f_col_ready, f_pix_x, f_pix_y, f_pix_color, f_pix_we, f_busy, f_frame_done} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: outputs %h, required 0",
                     {f_col_index, f_col_ready, f_pix_x, f_pix_y, f_pix_color, f_pix_we, f_busy, f_frame_done});
        end
        resetn = 1'b1;
        repeat (30) @(negedge clock);
        n_cmp++;
        if (f_done_cnt != d0 || f_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_abandon: done pulses=%0d busy=%b, required 0/0", f_done_cnt - d0, f_busy);
        end
        start_fill(3'd1, 3'd1);
        n_cmp++;
        if (f_col_index !== 8'd0 || f_col_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_restart: index=%0d ready=%b, required 0/1", f_col_index, f_col_ready);
        end
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_clear_mode();
        int  n;
        bit  ok;
        int  d0;
        int  exp_cycles;
        int  h;
        exp_cycles = 0;
        for (int x = 0; x < W; x++) begin
            c_hgt[x] = (x % 5 == 0) ? 7'd0 : 7'd3;
            c_clr[x] = 3'($urandom_range(1, 7));
        end
        c_hgt[9] = 7'd127;
        for (int x = 0; x < W; x++) begin
            h = (int'(c_hgt[x]) > H) ? H : int'(c_hgt[x]);
            exp_cycles += 1 + h;
        end
        build_expect(1'b1, 0, 0);
        c_got.delete();
        d0 = c_done_cnt;
        c_col_valid = 1'b1;
        @(negedge clock);
        c_start = 1'b1;
        @(negedge clock);
        c_start = 1'b0;
        n_cmp++;
        if (c_busy !== 1'b1 || c_col_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_enter: busy=%b ready=%b, required 1/0", c_busy, c_col_ready);
        end
        wait_for(2, 25000, n, ok);
        n_cmp++;
        if (!ok || n != W * H) begin
            n_err++;
            $display("FAIL clear_pass_length: first request after %0d cycles (seen=%b), required %0d", n, ok, W * H);
        end
        wait_for(1, 25000, n, ok);
        n_cmp++;
        if (!ok || n != exp_cycles) begin
            n_err++;
            $display("FAIL clear_draw_length: frame_done after %0d cycles (seen=%b), required %0d", n, ok, exp_cycles);
        end
        n_cmp++;
        if (c_pix_we !== 1'b1 || c_pix_x !== 8'd159 || c_pix_y !== 7'd60) begin
            n_err++;
            $display("FAIL clear_last_pixel: we=%b x=%0d y=%0d, required 1/159/60", c_pix_we, c_pix_x, c_pix_y);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (c_done_cnt - d0 != 1 || c_busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_done: pulses=%0d busy=%b, required 1/0", c_done_cnt - d0, c_busy);
        end
        report_pixels("clear_pixels", 1'b1);
    endtask

    initial begin
        for (int x = 0; x < W; x++) begin
            f_hgt[x] = '0; f_clr[x] = '0;
            c_hgt[x] = '0; c_clr[x] = '0;
        end
        test_reset();
        test_fill_basic();
        test_random_fill();
        test_reset_mid_frame();
        test_clear_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
